bmem_arbiter: RTL and testbench

//  Shares the single burst-memory port (bmem) between the I-cache and D-cache for CP2+.

---
 rtl/bmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bmem_arbiter.sv | 553 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// Burst-memory arbiter: shares one bmem port between the I-cache and D-cache.
// Each granted request moves one full cache line as BEATS sequential beats
// (lowest beat first). The requester then gets a single-cycle resp.
// All bmem_* and resp outputs are decoded from registers only.

module bmem_arbiter #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [31:0]          ic_address,
  input  logic                 ic_read,
  output logic [LINE_BITS-1:0] ic_rdata,
  output logic                 ic_resp,

  input  logic [31:0]          dc_address,
  input  logic                 dc_read,
  input  logic                 dc_write,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 dc_resp,

  output logic [31:0]          bmem_address,
  output logic                 bmem_read,
  output logic                 bmem_write,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_resp
);

  localparam int unsigned BEATS    = LINE_BITS / BEAT_BITS;
  localparam int unsigned OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFF_BITS) - 32'd1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;
  typedef enum logic {GntIc = 1'b0, GntDc = 1'b1} gnt_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q;
  gnt_e                 gnt_q, last_gnt_q, gnt_pick;
  logic                 op_wr_q;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] line_q;
  logic [BEAT_BITS-1:0] wdata_sel;
  logic                 ic_req, dc_req, any_req, last_beat;

  assign ic_req    = ic_read;
  assign dc_req    = dc_read | dc_write;
  assign any_req   = ic_req | dc_req;
  assign last_beat = bmem_resp && (beat_q == LAST_BEAT);

  // Grant selection: a sole requester wins; on a tie the side not served last wins.
  always_comb begin
    gnt_pick = GntIc;
    if (ic_req && dc_req) begin
      gnt_pick = (last_gnt_q == GntIc) ? GntDc : GntIc;
    end else if (dc_req) begin
      gnt_pick = GntDc;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StBurst;
      StBurst: if (last_beat) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: grant/address/op capture, beat counter, line buffer, fairness history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q     <= '0;
      gnt_q      <= GntIc;
      last_gnt_q <= GntIc;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      line_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q   <= gnt_pick;
            beat_q  <= '0;
            // Read+write from the D side together is a writeback.
            op_wr_q <= (gnt_pick == GntDc) && dc_write;
            addr_q  <= ((gnt_pick == GntDc) ? dc_address : ic_address) & ADDR_MASK;
            if ((gnt_pick == GntDc) && dc_write) begin
              line_q <= dc_wdata;
            end
          end
        end
        StBurst: begin
          if (bmem_resp) begin
            if (!op_wr_q) begin
              for (int unsigned i = 0; i < BEATS; i++) begin
                if (beat_q == BEAT_W'(i)) begin
                  line_q[i*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
                end
              end
            end
            beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
          end
        end
        StDone: begin
          last_gnt_q <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  // Select the write beat for the current beat index.
  always_comb begin
    wdata_sel = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat_q == BEAT_W'(i)) begin
        wdata_sel = line_q[i*BEAT_BITS +: BEAT_BITS];
      end
    end
  end

  assign bmem_address = addr_q;

  // Output decode from state and registered datapath only.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    ic_resp    = 1'b0;
    ic_rdata   = '0;
    dc_resp    = 1'b0;
    dc_rdata   = '0;
    unique case (state_q)
      StBurst: begin
        bmem_read  = !op_wr_q;
        bmem_write = op_wr_q;
        if (op_wr_q) begin
          bmem_wdata = wdata_sel;
        end
      end
      StDone: begin
        if (gnt_q == GntDc) begin
          dc_resp  = 1'b1;
          dc_rdata = line_q;
        end else begin
          ic_resp  = 1'b1;
          ic_rdata = line_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: a burst-memory responder with configurable
// beat gaps, a bus monitor that assembles each completed line, and per-scenario tests.

module tb_bmem_arbiter;

  localparam int LB = 256;
  localparam int BB = 64;
  localparam int NB = LB / BB;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   ic_address = '0;
  logic          ic_read = 1'b0;
  logic [LB-1:0] ic_rdata;
  logic          ic_resp;
  logic [31:0]   dc_address = '0;
  logic          dc_read = 1'b0;
  logic          dc_write = 1'b0;
  logic [LB-1:0] dc_wdata = '0;
  logic [LB-1:0] dc_rdata;
  logic          dc_resp;
  logic [31:0]   bmem_address;
  logic          bmem_read;
  logic          bmem_write;
  logic [BB-1:0] bmem_rdata = '0;
  logic [BB-1:0] bmem_wdata;
  logic          bmem_resp = 1'b0;

  bmem_arbiter #(.LINE_BITS(LB), .BEAT_BITS(BB)) dut (
    .clk(clk), .rst(rst),
    .ic_address(ic_address), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_rdata(bmem_rdata), .bmem_wdata(bmem_wdata), .bmem_resp(bmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory responder knobs.
  int gap_cfg  = 0;
  bit gap_rand = 0;
  bit pat_mode = 0;
  int pat_idx  = 0;
  int gap_cnt  = 0;

  // Memory responder: one beat per cycle unless gaps are configured.
  always begin
    logic [3:0] nib;
    @(posedge clk);
    #1;
    if (!rst) begin
      bmem_resp = 1'b0;
      gap_cnt   = 0;
    end else if (bmem_read || bmem_write) begin
      if (gap_cnt > 0) begin
        bmem_resp = 1'b0;
        gap_cnt--;
      end else begin
        bmem_resp = 1'b1;
        if (pat_mode) begin
          pat_idx++;
          nib = pat_idx[3:0];
          bmem_rdata = {16{nib}};
        end else begin
          bmem_rdata = {$urandom, $urandom};
        end
        gap_cnt = gap_rand ? $urandom_range(0, 3) : gap_cfg;
      end
    end else begin
      bmem_resp = 1'b0;
      gap_cnt   = 0;
    end
  end

  typedef struct {
    bit          dc;
    bit          wr;
    logic [LB-1:0] line;
    logic [LB-1:0] model;
    int          nbeats;
    logic [31:0] addr;
    int          cyc;
  } done_t;

  done_t       done_q[$];
  done_t       d;
  int          cyc = 0;
  int          first_req_cyc = -1;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          both_cycles = 0;
  int          addr_unstable = 0;
  int          rdata_leak = 0;
  int          cur_n = 0;
  bit          cur_wr = 0;
  bit          cur_addr_valid = 0;
  logic [31:0] cur_addr = '0;
  logic [LB-1:0] cur_model = '0;

  // Bus monitor: assembles each line from accepted beats, logs every resp pulse.
  always @(negedge clk) begin
    cyc++;
    if (bmem_read || bmem_write) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (cur_addr_valid && bmem_address !== cur_addr) addr_unstable++;
      cur_addr = bmem_address;
      cur_addr_valid = 1;
      cur_wr = bmem_write;
    end
    if (bmem_read) rd_cycles++;
    if (bmem_write) wr_cycles++;
    if (bmem_read && bmem_write) both_cycles++;
    if (bmem_resp && (bmem_read || bmem_write)) begin
      if (cur_n < NB) cur_model[cur_n*BB +: BB] = bmem_read ? bmem_rdata : bmem_wdata;
      cur_n++;
    end
    if ((ic_resp !== 1'b1 && ic_rdata !== '0) || (dc_resp !== 1'b1 && dc_rdata !== '0))
      rdata_leak++;
    if (ic_resp || dc_resp) begin
      d.dc = dc_resp;
      d.wr = cur_wr;
      d.line = dc_resp ? dc_rdata : ic_rdata;
      d.model = cur_model;
      d.nbeats = cur_n;
      d.addr = cur_addr;
      d.cyc = cyc;
      done_q.push_back(d);
      if (ic_resp && dc_resp) both_cycles++;
      cur_n = 0;
      cur_model = '0;
      cur_addr_valid = 0;
    end
  end

  task automatic clear_mon();
    done_q.delete();
    first_req_cyc = -1;
    rd_cycles = 0;
    wr_cycles = 0;
    cur_n = 0;
    cur_model = '0;
    cur_addr_valid = 0;
    pat_idx = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ic_read = 0;
    dc_read = 0;
    dc_write = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic start_req(input bit ic, input bit dr, input bit dw, input logic [31:0] ia,
                           input logic [31:0] da, input logic [LB-1:0] wd, output int rc);
    @(posedge clk);
    #2;
    ic_address = ia;
    dc_address = da;
    dc_wdata = wd;
    ic_read = ic;
    dc_read = dr;
    dc_write = dw;
    rc = cyc;
  endtask

  // Requesters drop their request once they have seen their resp.
  task automatic run_until_idle(input int budget, output bit to);
    int n = 0;
    to = 0;
    while (ic_read || dc_read || dc_write) begin
      @(negedge clk);
      #1;
      if (ic_resp) ic_read = 0;
      if (dc_resp) begin
        dc_read = 0;
        dc_write = 0;
      end
      n++;
      if (n > budget) begin
        to = 1;
        ic_read = 0;
        dc_read = 0;
        dc_write = 0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_round(input bit ic, input bit dr, input bit dw, input logic [31:0] ia,
                           input logic [31:0] da, input logic [LB-1:0] wd, output int rc,
                           output bit to);
    clear_mon();
    start_req(ic, dr, dw, ia, da, wd, rc);
    run_until_idle(200, to);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_bmem_rw: got r=%b w=%b expected 0 0", bmem_read, bmem_write);
    end
    checks++;
    if (bmem_address !== 32'h0 || bmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bmem_addr: got a=%h wd=%h expected 0", bmem_address, bmem_wdata);
    end
    checks++;
    if (ic_resp !== 1'b0 || dc_resp !== 1'b0 || ic_rdata !== '0 || dc_rdata !== '0) begin
      errors++;
      $display("FAIL reset_resp: got ic=%b dc=%b expected 0 0", ic_resp, dc_resp);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (bmem_read !== 1'b0 || ic_resp !== 1'b0 || dc_resp !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got r=%b ic=%b dc=%b expected 0", bmem_read, ic_resp,
               dc_resp);
    end
  endtask

  task automatic test_ic_read();
    int rc;
    bit to;
    logic [LB-1:0] exp_line;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    pat_mode = 1;
    gap_cfg = 0;
    run_round(1, 0, 0, 32'h0000_1234, 32'h0, '0, rc, to);
    pat_mode = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL ic_read_timeout: got %b expected 0", to); end
    checks++;
    if (done_q.size() !== 1) begin
      errors++;
      $display("FAIL ic_read_resp_count: got %0d expected 1", done_q.size());
    end else begin
      checks++;
      if (done_q[0].dc !== 1'b0) begin errors++; $display("FAIL ic_read_side: got D expected I"); end
      checks++;
      if (done_q[0].addr !== 32'h0000_1220) begin
        errors++;
        $display("FAIL ic_read_addr: got %h expected 00001220", done_q[0].addr);
      end
      checks++;
      if (done_q[0].line !== exp_line) begin
        errors++;
        $display("FAIL ic_read_data: got %h expected %h", done_q[0].line, exp_line);
      end
      checks++;
      if (done_q[0].cyc !== rc + NB + 2) begin
        errors++;
        $display("FAIL ic_read_latency: got %0d expected %0d", done_q[0].cyc - rc, NB + 2);
      end
    end
    checks++;
    if (first_req_cyc !== rc + 2) begin
      errors++;
      $display("FAIL ic_read_req_start: got %0d expected %0d", first_req_cyc - rc, 2);
    end
    checks++;
    if (wr_cycles !== 0 || rd_cycles !== NB) begin
      errors++;
      $display("FAIL ic_read_bus_cycles: got rd=%0d wr=%0d expected %0d 0", rd_cycles, wr_cycles,
               NB);
    end
  endtask

  task automatic test_dc_write();
    int rc;
    bit to;
    logic [LB-1:0] wd;
    wd = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF};
    clear_mon();
    start_req(0, 0, 1, 32'h0, 32'h8000_0040, wd, rc);
    // Corrupt the input after grant: the burst must use the value captured at grant.
    @(negedge clk);
    @(negedge clk);
    dc_wdata = ~wd;
    run_until_idle(200, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL dc_write_timeout: got %b expected 0", to); end
    checks++;
    if (done_q.size() !== 1) begin
      errors++;
      $display("FAIL dc_write_resp_count: got %0d expected 1", done_q.size());
    end else begin
      checks++;
      if (done_q[0].model !== wd || done_q[0].nbeats !== NB) begin
        errors++;
        $display("FAIL dc_write_beats: got %h (%0d beats) expected %h (%0d)", done_q[0].model,
                 done_q[0].nbeats, wd, NB);
      end
      checks++;
      if (done_q[0].dc !== 1'b1 || done_q[0].addr !== 32'h8000_0040) begin
        errors++;
        $display("FAIL dc_write_side_addr: got dc=%b a=%h expected 1 80000040", done_q[0].dc,
                 done_q[0].addr);
      end
    end
    checks++;
    if (rd_cycles !== 0 || wr_cycles !== NB) begin
      errors++;
      $display("FAIL dc_write_bus_cycles: got rd=%0d wr=%0d expected 0 %0d", rd_cycles, wr_cycles,
               NB);
    end
  endtask

  task automatic test_tie();
    int rc;
    bit to;
    apply_reset();
    run_round(1, 1, 0, 32'h0000_0100, 32'h0000_0200, '0, rc, to);
    checks++;
    if (to !== 1'b0 || done_q.size() !== 2) begin
      errors++;
      $display("FAIL tie1_count: got %0d resps (to=%b) expected 2", done_q.size(), to);
    end else begin
      checks++;
      if (done_q[0].dc !== 1'b1 || done_q[1].dc !== 1'b0) begin
        errors++;
        $display("FAIL tie1_order: got %b,%b expected D(1),I(0)", done_q[0].dc, done_q[1].dc);
      end
    end
    run_round(0, 1, 0, 32'h0, 32'h0000_0300, '0, rc, to);
    run_round(1, 1, 0, 32'h0000_0400, 32'h0000_0500, '0, rc, to);
    checks++;
    if (to !== 1'b0 || done_q.size() !== 2) begin
      errors++;
      $display("FAIL tie2_count: got %0d resps (to=%b) expected 2", done_q.size(), to);
    end else begin
      checks++;
      if (done_q[0].dc !== 1'b0 || done_q[1].dc !== 1'b1) begin
        errors++;
        $display("FAIL tie2_order: got %b,%b expected I(0),D(1)", done_q[0].dc, done_q[1].dc);
      end
      checks++;
      if (done_q[0].addr !== 32'h0000_0400 || done_q[1].addr !== 32'h0000_0500) begin
        errors++;
        $display("FAIL tie2_addr: got %h,%h expected 00000400,00000500", done_q[0].addr,
                 done_q[1].addr);
      end
    end
  endtask

  task automatic test_gaps();
    int rc;
    bit to;
    gap_cfg = 3;
    run_round(0, 1, 0, 32'h0, 32'h1234_567F, '0, rc, to);
    gap_cfg = 0;
    checks++;
    if (to !== 1'b0 || done_q.size() !== 1) begin
      errors++;
      $display("FAIL gaps_resp_count: got %0d (to=%b) expected 1", done_q.size(), to);
    end else begin
      checks++;
      if (done_q[0].line !== done_q[0].model || done_q[0].nbeats !== NB) begin
        errors++;
        $display("FAIL gaps_data: got %h expected %h", done_q[0].line, done_q[0].model);
      end
      checks++;
      if (done_q[0].cyc !== rc + 1 + NB + 3 * (NB - 1) + 1) begin
        errors++;
        $display("FAIL gaps_latency: got %0d expected %0d", done_q[0].cyc - rc,
                 NB + 3 * (NB - 1) + 2);
      end
      checks++;
      if (done_q[0].addr !== 32'h1234_5660) begin
        errors++;
        $display("FAIL gaps_addr: got %h expected 12345660", done_q[0].addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc;
    int n = 0;
    bit to;
    clear_mon();
    start_req(0, 1, 0, 32'h0, 32'h0000_2000, '0, rc);
    while (cur_n < 3 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (cur_n !== 3) begin
      errors++;
      $display("FAIL reset_mid_reach_beat2: got %0d beats expected 3", cur_n);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bmem_read !== 1'b0 || bmem_address !== 32'h0 || dc_resp !== 1'b0 || dc_rdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got r=%b a=%h resp=%b expected 0 0 0", bmem_read,
               bmem_address, dc_resp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_resp: got %0d resps expected 0", done_q.size());
    end
    clear_mon();
    @(posedge clk);
    #2;
    rst = 1'b1;
    rc = cyc;
    run_until_idle(200, to);
    checks++;
    if (to !== 1'b0 || done_q.size() !== 1) begin
      errors++;
      $display("FAIL reset_mid_restart_count: got %0d (to=%b) expected 1", done_q.size(), to);
    end else begin
      checks++;
      if (done_q[0].nbeats !== NB || done_q[0].line !== done_q[0].model) begin
        errors++;
        $display("FAIL reset_mid_restart_data: got %h (%0d beats) expected %h (%0d)",
                 done_q[0].line, done_q[0].nbeats, done_q[0].model, NB);
      end
    end
    checks++;
    if (first_req_cyc !== rc + 2) begin
      errors++;
      $display("FAIL reset_mid_restart_start: got %0d expected 2", first_req_cyc - rc);
    end
  endtask

  task automatic test_rw_both();
    int rc;
    bit to;
    logic [LB-1:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_round(0, 1, 1, 32'h0, 32'h0000_7788, wd, rc, to);
    checks++;
    if (to !== 1'b0 || done_q.size() !== 1) begin
      errors++;
      $display("FAIL rw_both_count: got %0d (to=%b) expected 1", done_q.size(), to);
    end else begin
      checks++;
      if (done_q[0].wr !== 1'b1 || done_q[0].model !== wd) begin
        errors++;
        $display("FAIL rw_both_write: got wr=%b %h expected 1 %h", done_q[0].wr, done_q[0].model,
                 wd);
      end
    end
    checks++;
    if (rd_cycles !== 0) begin
      errors++;
      $display("FAIL rw_both_no_read: got %0d read cycles expected 0", rd_cycles);
    end
  endtask

  task automatic test_random();
    int rc;
    bit to;
    bit last_dc;
    apply_reset();
    last_dc = 0;
    gap_rand = 1;
    for (int r = 0; r < 16; r++) begin
      int k;
      bit ic, dc, dw;
      bit exp_side[$];
      logic [31:0] ia, da;
      logic [LB-1:0] wd;
      k = $urandom_range(0, 3);
      ic = (k != 1);
      dc = (k != 0);
      dw = $urandom_range(0, 1);
      ia = $urandom;
      da = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (ic && dc) begin
        exp_side.push_back(!last_dc);
        exp_side.push_back(last_dc);
      end else begin
        exp_side.push_back(dc);
        last_dc = dc;
      end
      run_round(ic, dc && !dw, dc && dw, ia, da, wd, rc, to);
      checks++;
      if (to !== 1'b0 || done_q.size() !== exp_side.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d (to=%b) expected %0d", r, done_q.size(), to,
                 exp_side.size());
      end else begin
        for (int j = 0; j < exp_side.size(); j++) begin
          checks++;
          if (done_q[j].dc !== exp_side[j]) begin
            errors++;
            $display("FAIL rand%0d_side%0d: got %b expected %b", r, j, done_q[j].dc, exp_side[j]);
          end
          checks++;
          if (done_q[j].addr !== ((exp_side[j] ? da : ia) & LINE_MASK)
              || done_q[j].nbeats !== NB) begin
            errors++;
            $display("FAIL rand%0d_addr%0d: got %h (%0d beats) expected %h", r, j, done_q[j].addr,
                     done_q[j].nbeats, (exp_side[j] ? da : ia) & LINE_MASK);
          end
          checks++;
          if (exp_side[j] && dw) begin
            if (done_q[j].wr !== 1'b1 || done_q[j].model !== wd) begin
              errors++;
              $display("FAIL rand%0d_wdata%0d: got %h expected %h", r, j, done_q[j].model, wd);
            end
          end else if (done_q[j].wr !== 1'b0 || done_q[j].line !== done_q[j].model) begin
            errors++;
            $display("FAIL rand%0d_rdata%0d: got %h expected %h", r, j, done_q[j].line,
                     done_q[j].model);
          end
        end
      end
    end
    gap_rand = 0;
    checks++;
    if (rdata_leak !== 0 || both_cycles !== 0 || addr_unstable !== 0) begin
      errors++;
      $display("FAIL bus_invariants: got leak=%0d both=%0d addr_moves=%0d expected 0 0 0",
               rdata_leak, both_cycles, addr_unstable);
    end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_tie();
    test_gaps();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
